// File: rtl/fb_tile_writer_if.sv
// Command-in / framebuffer-write-out bundle for fb_tile_writer.
// Latency: none; this bundle carries only wires.
// Backpressure: cmd_valid/cmd_ready on the command side; the write side never stalls.
// Ports: cmd_* drawing command, wr_* framebuffer write port, busy/drop_count status,
//        clear_req single-cycle clear pulse (acted on only when FB_CLEAR_EN is defined).
interface fb_tile_writer_if #(
  parameter int COORD_W = 8,
  parameter int SIZE_W  = 4,
  parameter int COLOR_W = 8,
  parameter int ADDR_W  = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_x;
  logic [COORD_W-1:0] cmd_y;
  logic [SIZE_W-1:0]  cmd_w;
  logic [SIZE_W-1:0]  cmd_h;
  logic [COLOR_W-1:0] cmd_color;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               busy;
  logic [7:0]         drop_count;
  logic               clear_req;

  // Command source / write-port observer side.
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, clear_req,
    input  cmd_ready, wr_en, wr_addr, wr_data, busy, drop_count
  );

  // Engine side.
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, clear_req,
    output cmd_ready, wr_en, wr_addr, wr_data, busy, drop_count
  );
endinterface

// File: rtl/fb_tile_writer.sv
// Framebuffer write engine: queues rectangle fill commands and expands each into one RAM write per cycle.
// Latency: command accepted into an empty queue at edge N gives its first wr_en at edge N+3.
// Backpressure: cmd_ready = queue not full; the framebuffer write port is never stalled.
// Ports: clk, rst_n (async active-low), bus (fb_tile_writer_if.slave: cmd_*, wr_*, busy, drop_count, clear_req).
// Optional: define FB_CLEAR_EN to build the clear sweep (clear_req -> CLEAR_COLOR over the whole framebuffer).

// Small generic FIFO; dout shows the head entry whenever empty is low.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + (AW+1)'(1);
      else if (do_pop && !do_push) cnt <= cnt - (AW+1)'(1);
    end
  end
endmodule

module fb_tile_writer #(
  parameter int                 FB_W        = 240,
  parameter int                 FB_H        = 240,
  parameter int                 COORD_W     = 8,
  parameter int                 SIZE_W      = 4,
  parameter int                 COLOR_W     = 8,
  parameter int                 ADDR_W      = 16,
  parameter int                 CMD_DEPTH   = 4,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = COLOR_W'(8'h00)
) (
  input logic             clk,
  input logic             rst_n,
  fb_tile_writer_if.slave bus
);
  localparam int XY_W  = COORD_W + 1;  // one spare bit so x+w / y+h never wrap
  localparam int LIN_W = XY_W + ADDR_W;
  localparam int LVL_W = $clog2(CMD_DEPTH) + 1;
  localparam logic [XY_W-1:0] FB_W_C = XY_W'(FB_W);
  localparam logic [XY_W-1:0] FB_H_C = XY_W'(FB_H);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
`ifdef FB_CLEAR_EN
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);
`endif

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [SIZE_W-1:0]  w;
    logic [SIZE_W-1:0]  h;
    logic [COLOR_W-1:0] color;
  } cmd_t;

  cmd_t             fifo_din, fifo_dout;
  logic             push, pop, full, empty;
  logic [LVL_W-1:0] level;

  logic [1:0]         state, state_nxt;
  logic [XY_W-1:0]    cur_x, cur_y, x0, x_end, y_end;
  logic [COLOR_W-1:0] color;
  logic [7:0]         drop_cnt;
  logic               cmd_in_range, px_in_range, last_px, fifo_nonempty_nxt;
  logic [LIN_W-1:0]   px_lin;

  // Pixel stage (one cycle after the FILL/CLEAR cycle) and registered write port.
  logic               pix_vld;
  logic [ADDR_W-1:0]  pix_addr;
  logic [COLOR_W-1:0] pix_data;
  logic               wr_en_q, busy_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [COLOR_W-1:0] wr_data_q;

  assign fifo_din      = {bus.cmd_x, bus.cmd_y, bus.cmd_w, bus.cmd_h, bus.cmd_color};
  assign push          = bus.cmd_valid && !full;
  assign bus.cmd_ready = !full;

  sync_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

`ifdef FB_CLEAR_EN
  logic              clr_pend;
  logic [ADDR_W-1:0] clr_addr;

  // A pending clear wins over queued commands at the next IDLE cycle.
  assign pop = (state == S_IDLE) && !empty && !clr_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_pend <= 1'b0;
      clr_addr <= '0;
    end else if (state == S_CLEAR) begin
      if (clr_addr == CLR_LAST) begin
        clr_pend <= 1'b0;
        clr_addr <= '0;
      end else begin
        clr_addr <= clr_addr + ADDR_W'(1);
      end
    end else if (bus.clear_req) begin
      clr_pend <= 1'b1;
    end
  end
`else
  logic unused_clear_req;
  assign unused_clear_req = bus.clear_req;
  assign pop = (state == S_IDLE) && !empty;
`endif

  assign cmd_in_range = ({1'b0, fifo_dout.x} < FB_W_C) && ({1'b0, fifo_dout.y} < FB_H_C);
  assign px_in_range  = (cur_x < FB_W_C) && (cur_y < FB_H_C);
  assign last_px      = (cur_x == x_end) && (cur_y == y_end);
  assign px_lin       = LIN_W'(cur_x) * LIN_W'(FB_H) + LIN_W'(cur_y);
  assign fifo_nonempty_nxt = push || (level > LVL_W'(1)) || (!empty && !pop);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
`ifdef FB_CLEAR_EN
        if (clr_pend) state_nxt = S_CLEAR;
        else
`endif
        if (pop && cmd_in_range) state_nxt = S_FILL;
      end
      S_FILL: if (last_px) state_nxt = S_IDLE;
`ifdef FB_CLEAR_EN
      S_CLEAR: if (clr_addr == CLR_LAST) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cur_x     <= '0;
      cur_y     <= '0;
      x0        <= '0;
      x_end     <= '0;
      y_end     <= '0;
      color     <= '0;
      drop_cnt  <= '0;
      pix_vld   <= 1'b0;
      pix_addr  <= '0;
      pix_data  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (pop) begin
        x0    <= {1'b0, fifo_dout.x};
        cur_x <= {1'b0, fifo_dout.x};
        cur_y <= {1'b0, fifo_dout.y};
        x_end <= {1'b0, fifo_dout.x} + XY_W'(fifo_dout.w);
        y_end <= {1'b0, fifo_dout.y} + XY_W'(fifo_dout.h);
        color <= fifo_dout.color;
        if (!cmd_in_range && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (state == S_FILL) begin
        // x runs fastest; off-screen pixels still take their cycle.
        if (cur_x == x_end) begin
          cur_x <= x0;
          cur_y <= cur_y + XY_W'(1);
        end else begin
          cur_x <= cur_x + XY_W'(1);
        end
      end

      pix_vld <= 1'b0;
      if (state == S_FILL) begin
        pix_vld  <= px_in_range;
        pix_addr <= px_lin[ADDR_W-1:0];
        pix_data <= color;
      end
`ifdef FB_CLEAR_EN
      else if (state == S_CLEAR) begin
        pix_vld  <= 1'b1;
        pix_addr <= clr_addr;
        pix_data <= CLEAR_COLOR;
      end
`endif

      // Address/data hold their last written values while wr_en is low.
      wr_en_q <= pix_vld;
      if (pix_vld) begin
        wr_addr_q <= pix_addr;
        wr_data_q <= pix_data;
      end

      // Covers the queue, the FSM and both pipeline stages, so busy drops
      // one cycle after the final write has been registered.
      busy_q <= (state_nxt != S_IDLE) || (state != S_IDLE) || fifo_nonempty_nxt || pix_vld;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_q;
  assign bus.drop_count = drop_cnt;
endmodule

// File: tb/tb_fb_tile_writer.sv
// Testbench for fb_tile_writer: directed scenarios plus randomized commands against a rectangle-expansion model.
// Latency: checks first-write timing (accept edge + 3) and busy fall (accept edge + 4) for a single pixel.
// Backpressure: checks the queue fills to 4 entries and the 5th command waits for the first pop.
module tb_fb_tile_writer;
  localparam int         FB_W      = 240;
  localparam int         FB_H      = 240;
  localparam logic [7:0] CLR_COLOR = 8'h00;

  typedef struct { int addr; int data; } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int  n_checks  = 0;
  int  n_pass    = 0;
  int  n_fail    = 0;
  int  edge_cnt  = 0;
  int  n_wr      = 0;
  int  exp_drops = 0;
  bit  stuck     = 1'b0;
  wr_t exp_q[$];
  wr_t mon_e;
  int  wr_edges[$];
  bit  busy_hist[int];

  fb_tile_writer_if bus ();

  fb_tile_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #20 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: a command is a rectangle of (w+1)x(h+1) pixels, row by row,
  // keeping only on-screen pixels; an off-screen origin is a drop.
  task automatic model_cmd(input int x, input int y, input int w, input int h, input int c);
    if (x >= FB_W || y >= FB_H) begin
      if (exp_drops < 255) exp_drops++;
    end else begin
      for (int dy = 0; dy <= h; dy++)
        for (int dx = 0; dx <= w; dx++)
          if (x + dx < FB_W && y + dy < FB_H)
            exp_q.push_back('{(x + dx) * FB_H + (y + dy), c});
    end
  endtask

  // Write-port monitor: every write must be the next one the model predicts.
  always @(negedge clk) begin
    if (rst_n) begin
      busy_hist[edge_cnt] = bus.busy;
      if (bus.wr_en) begin
        n_wr++;
        wr_edges.push_back(edge_cnt);
        check("write_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("wr_addr", bus.wr_addr, mon_e.addr);
          check("wr_data", bus.wr_data, mon_e.data);
        end
      end
    end
  end

  function automatic int edge_at(input int i);
    return (i < wr_edges.size()) ? wr_edges[i] : -1000;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge with
  // cmd_valid still high, so the caller drives the next command or drops valid.
  task automatic send(input int x, input int y, input int w, input int h, input int c,
                      output int acc);
    logic rdy;
    int   budget;
    acc = -1;
    budget = stuck ? 1 : 600;
    bus.cmd_x     = 8'(x);
    bus.cmd_y     = 8'(y);
    bus.cmd_w     = 4'(w);
    bus.cmd_h     = 4'(h);
    bus.cmd_color = 8'(c);
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < budget; t++) begin
      rdy = bus.cmd_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        acc = edge_cnt;
        break;
      end
    end
    if (acc < 0) stuck = 1'b1;
    check("cmd_accepted", int'(acc >= 0), 1);
    if (acc >= 0) model_cmd(x, y, w, h, c);
  endtask

  task automatic wait_idle(input int bound);
    bit done;
    done = 1'b0;
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if (!bus.busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_reached", int'(done), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int a0, a1, acc, x, y, nexp;
    bus.cmd_valid = 1'b0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_w     = '0;
    bus.cmd_h     = '0;
    bus.cmd_color = '0;
    bus.clear_req = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_drop_count", bus.drop_count, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single pixel: addr 3*240+5 = 725
    wr_edges.delete();
    send(3, 5, 0, 0, 8'hE0, a0);
    bus.cmd_valid = 1'b0;
    wait_idle(200);
    check("px_count", wr_edges.size(), 1);
    check("px_latency", edge_at(0) - a0, 3);
    check("px_busy_at_write", busy_hist[a0 + 3], 1);
    check("px_busy_fall", busy_hist[a0 + 4], 0);

    // 2x2 fill: 2420, 2660, 2421, 2661 back to back
    wr_edges.delete();
    send(10, 20, 1, 1, 8'h1C, a0);
    bus.cmd_valid = 1'b0;
    wait_idle(200);
    check("fill_count", wr_edges.size(), 4);
    check("fill_first", edge_at(0) - a0, 3);
    check("fill_no_gaps", edge_at(3) - edge_at(0), 3);

    // Right-edge clip: only 57360 is written
    wr_edges.delete();
    send(239, 0, 1, 0, 8'h03, a0);
    bus.cmd_valid = 1'b0;
    wait_idle(200);
    check("clip_count", wr_edges.size(), 1);

    // Drops: one, then 300 more to saturate
    wr_edges.delete();
    send(240, 7, 0, 0, 8'hFF, a0);
    bus.cmd_valid = 1'b0;
    wait_idle(200);
    check("drop_no_write", wr_edges.size(), 0);
    check("drop_one", bus.drop_count, exp_drops);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) begin
        x = $urandom_range(240, 255);
        y = $urandom_range(0, 255);
      end else begin
        x = $urandom_range(0, 239);
        y = $urandom_range(240, 255);
      end
      send(x, y, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255), acc);
    end
    bus.cmd_valid = 1'b0;
    wait_idle(400);
    check("drop_no_write_burst", wr_edges.size(), 0);
    check("drop_saturate", bus.drop_count, exp_drops);

    // Backpressure: 16x16 then 5 single pixels back to back
    wr_edges.delete();
    send(0, 0, 15, 15, 8'h55, a0);
    send(100, 100, 0, 0, 8'h01, acc);
    send(101, 101, 0, 0, 8'h02, acc);
    send(102, 102, 0, 0, 8'h03, acc);
    send(103, 103, 0, 0, 8'h04, a1);
    check("bp_queue_fill", a1 - a0, 4);
    check("bp_ready_low", bus.cmd_ready, 0);
    send(104, 104, 0, 0, 8'h05, acc);
    bus.cmd_valid = 1'b0;
    check("bp_held_until_pop", acc - a0, 259);
    wait_idle(600);
    check("bp_write_count", wr_edges.size(), 261);

    // Reset mid-fill with commands still queued
    send(0, 0, 15, 15, 8'hAA, a0);
    send(5, 5, 0, 0, 8'h11, acc);
    send(6, 6, 0, 0, 8'h22, acc);
    bus.cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_rst_wr_en", bus.wr_en, 1);
    #7 rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", bus.wr_en, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    check("mid_rst_wr_addr", bus.wr_addr, 0);
    exp_q.delete();
    exp_drops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    n_wr = 0;
    repeat (400) @(negedge clk);
    check("post_rst_writes", n_wr, 0);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_drop_count", bus.drop_count, 0);

    // Randomized commands with random idle gaps
    for (int i = 0; i < 60; i++) begin
      bus.cmd_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      x = ($urandom_range(0, 15) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 239);
      y = ($urandom_range(0, 15) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 239);
      send(x, y, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255), acc);
    end
    bus.cmd_valid = 1'b0;
    wait_idle(3000);
    check("rand_drain", exp_q.size(), 0);
    check("rand_drop_count", bus.drop_count, exp_drops);

`ifdef FB_CLEAR_EN
    // Clear sweep, then the commands queued behind it
    wr_edges.delete();
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    for (int a = 0; a < FB_W * FB_H; a++) exp_q.push_back('{a, CLR_COLOR});
    send(7, 9, 1, 0, 8'h77, acc);
    send(20, 30, 0, 1, 8'h88, acc);
    bus.cmd_valid = 1'b0;
    nexp = FB_W * FB_H + 4;
    wait_idle(60000);
    check("clear_write_count", wr_edges.size(), nexp);
`else
    nexp = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
